char_buffer_arbiter: RTL and testbench

Owns the single-port 4096x8 character buffer BSRAM and shares it between three requesters: the VGA character fetch (read), the terminal host writer (keyboard/console path), and a built-in screen-clear sequencer. Video always wins, so the pixel pipeline never stalls. The host and clear engine use idle cycles only. The block sits between the text-mode VGA engine, the terminal logic and the charBuffer RAM macro.

---
 rtl/char_buffer_arbiter.sv | 143 ++++++++++++++
 tb/tb_char_buffer_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_buffer_arbiter.sv
// Arbiter for the single-port character buffer RAM: video fetch, screen-clear engine, host writer.
// Optional host read-back path enabled by defining CHARBUF_HOST_READ_EN.
module char_buffer_arbiter #(
    parameter int                ADDR_W      = 12,
    parameter int                DATA_W      = 8,
    parameter int                CLEAR_DEPTH = 2400,
    parameter logic [DATA_W-1:0] FILL_CHAR   = 8'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
`ifdef CHARBUF_HOST_READ_EN
    input  logic              host_we,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
`endif
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_reset,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLEAR_DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              clr_busy_q;
    logic              vid_valid_q;
    logic              clr_wr;
    logic              host_xfer;
    logic              host_wr_en;

`ifdef CHARBUF_HOST_READ_EN
    logic host_rvalid_q;
    assign host_wr_en  = host_we;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rvalid_q ? ram_dout : '0;
`else
    assign host_wr_en  = 1'b1;
`endif

    // Clear and host only get cycles that video leaves free; reset blocks every access.
    assign clr_wr     = (state_q == CLEAR) & ~vid_req & ~reset;
    assign host_ready = (state_q == IDLE) & ~vid_req & ~clr_start & ~reset;
    assign host_xfer  = host_req & host_ready;

    assign ram_oce   = 1'b1;
    assign ram_reset = reset;
    assign clr_busy  = clr_busy_q;
    assign vid_valid = vid_valid_q;
    assign vid_data  = vid_valid_q ? ram_dout : '0;

    always_comb begin
        ram_ce  = 1'b0;
        ram_wre = 1'b0;
        ram_ad  = vid_addr;
        ram_din = host_wdata;
        if (reset) begin
            ram_ce = 1'b0;
        end else if (vid_req) begin
            ram_ce = 1'b1;
            ram_ad = vid_addr;
        end else if (clr_wr) begin
            ram_ce  = 1'b1;
            ram_wre = 1'b1;
            ram_ad  = clr_cnt_q;
            ram_din = FILL_CHAR;
        end else if (host_xfer) begin
            ram_ce  = 1'b1;
            ram_wre = host_wr_en;
            ram_ad  = host_addr;
            ram_din = host_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_start) begin
                        state_q    <= CLEAR;
                        clr_cnt_q  <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    // A video cycle steals the port, so the counter holds.
                    if (!vid_req) begin
                        if (clr_cnt_q == CLR_LAST) begin
                            state_q    <= IDLE;
                            clr_cnt_q  <= '0;
                            clr_busy_q <= 1'b0;
                        end else begin
                            clr_cnt_q <= clr_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    clr_cnt_q  <= '0;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_valid_q <= 1'b0;
        end else begin
            vid_valid_q <= vid_req;
        end
    end

`ifdef CHARBUF_HOST_READ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_rvalid_q <= 1'b0;
        end else begin
            host_rvalid_q <= host_xfer & ~host_we;
        end
    end
`endif

endmodule

// File: tb/tb_char_buffer_arbiter.sv
// Self-checking bench for char_buffer_arbiter with a behavioural RAM and a video read scoreboard.
module tb_char_buffer_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [11:0] vid_addr;
    logic        vid_valid;
    logic [7:0]  vid_data;
    logic        host_req;
    logic [11:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ready;
`ifdef CHARBUF_HOST_READ_EN
    logic        host_we;
    logic        host_rvalid;
    logic [7:0]  host_rdata;
`endif
    logic        clr_start;
    logic        clr_busy;
    logic        ram_ce;
    logic        ram_oce;
    logic        ram_reset;
    logic        ram_wre;
    logic [11:0] ram_ad;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    logic [7:0]  mem     [4096];
    logic [7:0]  ref_mem [4096];
    logic [7:0]  sb_q    [$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    char_buffer_arbiter dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
        .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata), .host_ready(host_ready),
`ifdef CHARBUF_HOST_READ_EN
        .host_we(host_we), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
`endif
        .clr_start(clr_start), .clr_busy(clr_busy),
        .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_reset(ram_reset), .ram_wre(ram_wre),
        .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Single-port RAM, one-cycle read latency, write-through on dout.
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) begin
                mem[ram_ad] <= ram_din;
                ram_dout    <= ram_din;
            end else begin
                ram_dout <= mem[ram_ad];
            end
        end
    end

    typedef struct {
        logic        vr;
        logic [11:0] va;
        logic        hr;
        logic [11:0] ha;
        logic [7:0]  hd;
        logic        e_rdy;
        logic        e_ce;
        logic        e_wre;
        logic [11:0] e_ad;
        logic [7:0]  e_din;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: check video valid/data at the falling edge, enqueue new reads, step to posedge+1.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("vid_valid", 32'(vid_valid), 32'd1);
            chk("vid_data", 32'(vid_data), 32'(e));
        end else begin
            chk("vid_valid_idle", 32'(vid_valid), 32'd0);
        end
        if (vid_req && !reset) sb_q.push_back(ref_mem[vid_addr]);
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [11:0] a, input logic [7:0] d);
        host_req = 1'b1; host_addr = a; host_wdata = d;
        #1;
        chk("host_wr_ready", 32'(host_ready), 32'd1);
        ref_mem[a] = d;
        tick();
        host_req = 1'b0;
    endtask

    task automatic vid_rd(input logic [11:0] a);
        vid_req = 1'b1; vid_addr = a;
        tick();
        vid_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        reset = 1'b1; vid_req = 1'b0; vid_addr = '0; host_req = 1'b1; host_addr = 12'h005;
        host_wdata = 8'h41; clr_start = 1'b0;
`ifdef CHARBUF_HOST_READ_EN
        host_we = 1'b1;
`endif
        vecs[0] = '{1'b0, 12'h000, 1'b1, 12'h005, 8'h41, 1'b1, 1'b1, 1'b1, 12'h005, 8'h41};
        vecs[1] = '{1'b1, 12'h005, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0, 12'h005, 8'h00};
        vecs[2] = '{1'b1, 12'h005, 1'b1, 12'h006, 8'h42, 1'b0, 1'b1, 1'b0, 12'h005, 8'h00};
        vecs[3] = '{1'b0, 12'h000, 1'b1, 12'h006, 8'h42, 1'b1, 1'b1, 1'b1, 12'h006, 8'h42};
        vecs[4] = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00};
        vecs[5] = '{1'b1, 12'h006, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0, 12'h006, 8'h00};
        vecs[6] = '{1'b0, 12'h000, 1'b1, 12'hFFF, 8'h13, 1'b1, 1'b1, 1'b1, 12'hFFF, 8'h13};
        vecs[7] = '{1'b1, 12'hFFF, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0, 12'hFFF, 8'h00};
        vecs[8] = '{1'b1, 12'h006, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0, 12'h006, 8'h00};

        // Reset state, with requests present that must be blocked.
        repeat (3) @(posedge clk);
        #1;
        vid_req = 1'b1;
        #1;
        chk("rst_ram_ce", 32'(ram_ce), 32'd0);
        chk("rst_ram_wre", 32'(ram_wre), 32'd0);
        chk("rst_host_ready", 32'(host_ready), 32'd0);
        chk("rst_clr_busy", 32'(clr_busy), 32'd0);
        chk("rst_vid_valid", 32'(vid_valid), 32'd0);
        chk("rst_vid_data", 32'(vid_data), 32'd0);
        chk("ram_oce", 32'(ram_oce), 32'd1);
        chk("ram_reset", 32'(ram_reset), 32'd1);
        vid_req = 1'b0; host_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("ram_reset_rel", 32'(ram_reset), 32'd0);
        $display("reset sequence done");

        // Table: combinational mux in IDLE, video reads verified through the scoreboard.
        for (int i = 0; i < 9; i++) begin
            vid_req = vecs[i].vr; vid_addr = vecs[i].va;
            host_req = vecs[i].hr; host_addr = vecs[i].ha; host_wdata = vecs[i].hd;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(host_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_ce", i), 32'(ram_ce), 32'(vecs[i].e_ce));
            chk($sformatf("v%0d_wre", i), 32'(ram_wre), 32'(vecs[i].e_wre));
            if (vecs[i].e_ce) chk($sformatf("v%0d_ad", i), 32'(ram_ad), 32'(vecs[i].e_ad));
            if (vecs[i].e_wre) chk($sformatf("v%0d_din", i), 32'(ram_din), 32'(vecs[i].e_din));
            if (vecs[i].hr && vecs[i].e_rdy) ref_mem[vecs[i].ha] = vecs[i].hd;
            $display("vector %0d vr=%0b va=%h hr=%0b ha=%h hd=%h", i, vecs[i].vr, vecs[i].va,
                     vecs[i].hr, vecs[i].ha, vecs[i].hd);
            tick();
        end
        vid_req = 1'b0; host_req = 1'b0;
        tick();
        tick();

        // Video held 8 cycles starves a pending host write.
        host_req = 1'b1; host_addr = 12'h010; host_wdata = 8'h55;
        for (int i = 0; i < 8; i++) begin
            vid_req = 1'b1; vid_addr = 12'h005;
            #1;
            chk("starve_ready", 32'(host_ready), 32'd0);
            tick();
        end
        vid_req = 1'b0;
        #1;
        chk("starve_release_ready", 32'(host_ready), 32'd1);
        ref_mem[12'h010] = 8'h55;
        tick();
        host_req = 1'b0;
        vid_rd(12'h010);
        tick();
        $display("video starvation sequence done");

        // Full clear with no video; host request collides with clr_start and must wait.
        host_wr(12'd0, 8'h11);
        host_wr(12'd2399, 8'h11);
        host_wr(12'd2400, 8'hAB);
        host_req = 1'b1; host_addr = 12'd3002; host_wdata = 8'h66; clr_start = 1'b1;
        #1;
        chk("clr_start_ready", 32'(host_ready), 32'd0);
        tick();
        clr_start = 1'b0;
        n = 0;
        while (clr_busy && n < 5000) begin
            n++;
            if (n == 10) chk("clear_host_ready", 32'(host_ready), 32'd0);
            tick();
        end
        chk("clear_len", 32'(n), 32'd2400);
        for (int i = 0; i < 2400; i++) ref_mem[i] = 8'h20;
        chk("post_clear_ready", 32'(host_ready), 32'd1);
        ref_mem[12'd3002] = 8'h66;
        tick();
        host_req = 1'b0;
        vid_rd(12'd0); vid_rd(12'd1199); vid_rd(12'd2399); vid_rd(12'd2400); vid_rd(12'd3002);
        tick();
        $display("full clear sequence done, cycles=%0d", n);

        // Clear interleaved with video every 4th cycle and an ignored restart.
        for (int i = 0; i < 2400; i++) host_wr(12'(i), 8'hCC);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        n = 0;
        while (clr_busy && n < 5000) begin
            vid_req = (n % 4 == 0); vid_addr = 12'd3002;
            clr_start = (n == 1000);
            n++;
            tick();
        end
        vid_req = 1'b0; clr_start = 1'b0;
        chk("shared_clear_len", 32'(n), 32'd3200);
        for (int i = 0; i < 2400; i++) ref_mem[i] = 8'h20;
        tick();
        for (int i = 0; i < 2400; i++) begin
            vid_req = 1'b1; vid_addr = 12'(i);
            tick();
        end
        vid_req = 1'b0;
        tick();
        $display("shared clear sequence done, cycles=%0d", n);

        // Reset while clr_cnt sits at 1000 with a video result in flight.
        host_wr(12'd999, 8'hDD);
        host_wr(12'd1000, 8'hDD);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 1000; i++) tick();
        vid_req = 1'b1; vid_addr = 12'd3002;
        tick();
        vid_req = 1'b0;
        chk("pre_rst_vid_valid", 32'(vid_valid), 32'd1);
        chk("pre_rst_busy", 32'(clr_busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(clr_busy), 32'd0);
        chk("midrst_vid_valid", 32'(vid_valid), 32'd0);
        chk("midrst_vid_data", 32'(vid_data), 32'd0);
        sb_q.delete();
        host_req = 1'b1; host_addr = 12'd3001; host_wdata = 8'h77;
        #1;
        chk("midrst_ready", 32'(host_ready), 32'd0);
        chk("midrst_ce", 32'(ram_ce), 32'd0);
        chk("midrst_wre", 32'(ram_wre), 32'd0);
        repeat (2) tick();
        host_req = 1'b0;
        reset = 1'b0;
        #1;
        chk("after_rst_ready", 32'(host_ready), 32'd1);
        chk("after_rst_busy", 32'(clr_busy), 32'd0);
        ref_mem[12'd999] = 8'h20;
        vid_rd(12'd999); vid_rd(12'd1000);
        tick();
        $display("mid-clear reset sequence done");

`ifdef CHARBUF_HOST_READ_EN
        host_wr(12'hFFF, 8'h7E);
        host_req = 1'b1; host_we = 1'b0; host_addr = 12'hFFF;
        #1;
        chk("hrd_ready", 32'(host_ready), 32'd1);
        chk("hrd_ce", 32'(ram_ce), 32'd1);
        chk("hrd_wre", 32'(ram_wre), 32'd0);
        tick();
        host_req = 1'b0; host_we = 1'b1;
        chk("hrd_rvalid", 32'(host_rvalid), 32'd1);
        chk("hrd_rdata", 32'(host_rdata), 32'h7E);
        chk("hrd_vid_valid", 32'(vid_valid), 32'd0);
        tick();
        chk("hrd_rvalid_end", 32'(host_rvalid), 32'd0);
        vid_rd(12'hFFF);
        chk("vrd_no_rvalid", 32'(host_rvalid), 32'd0);
        tick();
        $display("host read sequence done");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
